// File: rtl/serdes_ecc_pkg.sv
`timescale 1ns/1ps
// SECDED helpers for the multi-lane serdes loopback.
// Codewords are Hamming-ordered (position p at bit p-1) with overall parity at the MSB.
package serdes_ecc_pkg;

  localparam int MAX_DATA = 64;
  localparam int MAX_PAR  = 7;
  localparam int MAX_CODE = MAX_DATA + MAX_PAR + 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} tx_state_t;

  typedef struct packed {
    logic [MAX_DATA-1:0] data;
    logic                corr;
    logic                uncorr;
  } secded_result_t;

  function automatic int calc_parity_bits(input int data_width);
    int p;
    p = 0;
    for (int i = MAX_PAR; i >= 1; i--)
      if ((1 << i) >= data_width + i + 1) p = i;
    return p;
  endfunction

  function automatic int calc_code_width(input int data_width);
    return data_width + calc_parity_bits(data_width) + 1;
  endfunction

  function automatic logic [MAX_CODE-1:0] secded_encode(input logic [MAX_DATA-1:0] data,
                                                        input int data_width);
    logic [MAX_CODE-1:0] code;
    logic [MAX_DATA-1:0] rem;
    logic                par;
    int                  p;
    int                  n;
    p    = calc_parity_bits(data_width);
    n    = data_width + p;
    code = '0;
    rem  = data;
    for (int pos = 1; pos < MAX_CODE; pos++) begin
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        code[pos-1] = rem[0];
        rem         = rem >> 1;
      end
    end
    for (int i = 0; i < MAX_PAR; i++) begin
      if (i < p) begin
        par = 1'b0;
        for (int pos = 1; pos < MAX_CODE; pos++)
          if (pos <= n && (pos & (1 << i)) != 0) par ^= code[pos-1];
        for (int pos = 1; pos < MAX_CODE; pos++)
          if (pos == (1 << i)) code[pos-1] = par;
      end
    end
    par = ^code;
    for (int b = 0; b < MAX_CODE; b++)
      if (b == n) code[b] = par;
    return code;
  endfunction

  function automatic secded_result_t secded_decode(input logic [MAX_CODE-1:0] code,
                                                   input int data_width);
    secded_result_t      res;
    logic [MAX_CODE-1:0] fixed;
    logic                overall;
    int                  p;
    int                  n;
    int                  syn;
    int                  di;
    p       = calc_parity_bits(data_width);
    n       = data_width + p;
    syn     = 0;
    overall = 1'b0;
    for (int pos = 1; pos < MAX_CODE; pos++)
      if (pos <= n && code[pos-1]) syn ^= pos;
    for (int b = 0; b < MAX_CODE; b++)
      if (b <= n) overall ^= code[b];
    fixed = code;
    res   = '0;
    // Odd overall parity means one flipped bit; syndrome 0 then points at the parity MSB itself.
    if (overall) begin
      res.corr = 1'b1;
      for (int pos = 1; pos < MAX_CODE; pos++)
        if (pos <= n && pos == syn) fixed[pos-1] = ~fixed[pos-1];
    end else if (syn != 0) begin
      res.uncorr = 1'b1;
    end
    di = 0;
    for (int pos = 1; pos < MAX_CODE; pos++) begin
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        if (fixed[pos-1]) res.data = res.data | (MAX_DATA'(1) << di);
        di++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// First-word-fall-through synchronous FIFO; full/empty come from a registered occupancy count.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_wr;
  logic                  do_rd;

  assign full_o    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty_o   = (count == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_data_i;
  end

endmodule

// File: rtl/serdes_ecc_mlane.sv
`timescale 1ns/1ps
// SECDED-protected serializer with LANES bits per beat, looped back into a deserializer/decoder.
// Words queue in sync_fifo; back-to-back frames reload on the last beat with no bubble.
module serdes_ecc_mlane
  import serdes_ecc_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int LANES      = 1,
  parameter  int CNT_WIDTH  = 16,
  localparam int CODE_WIDTH = calc_code_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] parallel_in_i,
  input  logic                  valid_in_i,
  output logic                  ready_out_o,
  input  logic                  inject_en_i,
  input  logic [CODE_WIDTH-1:0] inject_mask_i,
  output logic [LANES-1:0]      serial_o,
  output logic                  busy_o,
  output logic [DATA_WIDTH-1:0] parallel_out_o,
  output logic                  valid_out_o,
  output logic                  err_corr_o,
  output logic                  err_uncorr_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o
);

  localparam int BEATS   = (CODE_WIDTH + LANES - 1) / LANES;
  localparam int SHIFT_W = BEATS * LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DEC_W   = DATA_WIDTH + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  tx_state_t             state;
  logic [BEAT_W-1:0]     beat;
  logic [SHIFT_W-1:0]    tx_code;
  logic [SHIFT_W-1:0]    rx_code;
  logic [SHIFT_W-1:0]    next_code;
  logic [CODE_WIDTH-1:0] enc_code;
  logic [DEC_W-1:0]      dec_bits;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_pop;
  logic                  last_beat;
  logic                  rx_pending;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (valid_in_i),
    .wr_data_i (parallel_in_i),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full_o),
    .empty_o   (fifo_empty_o)
  );

  assign ready_out_o = !fifo_full_o;
  assign last_beat   = (state == ST_SHIFT) && (beat == LAST_BEAT);
  assign fifo_pop    = !fifo_empty_o && ((state == ST_IDLE) || last_beat);
  assign busy_o      = (state == ST_SHIFT) || rx_pending;
  assign serial_o    = (state == ST_SHIFT) ? tx_code[LANES-1:0] : '0;

  assign enc_code = CODE_WIDTH'(secded_encode(MAX_DATA'(fifo_rd_data), DATA_WIDTH));
  // The packed result truncates to {data[DATA_WIDTH-1:0], corr, uncorr}.
  assign dec_bits = DEC_W'(secded_decode(MAX_CODE'(rx_code), DATA_WIDTH));

  always_comb begin
    next_code                   = '0;
    next_code[CODE_WIDTH-1:0]   = enc_code ^ (inject_en_i ? inject_mask_i : '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      beat    <= '0;
      tx_code <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            state   <= ST_SHIFT;
            beat    <= '0;
            tx_code <= next_code;
          end
        end
        ST_SHIFT: begin
          if (last_beat) begin
            beat <= '0;
            if (fifo_pop) begin
              tx_code <= next_code;
            end else begin
              state   <= ST_IDLE;
              tx_code <= '0;
            end
          end else begin
            beat    <= beat + 1'b1;
            tx_code <= tx_code >> LANES;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Beats enter at the top and slide down, so after BEATS captures beat 0 sits at bit 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_code        <= '0;
      rx_pending     <= 1'b0;
      parallel_out_o <= '0;
      valid_out_o    <= 1'b0;
      err_corr_o     <= 1'b0;
      err_uncorr_o   <= 1'b0;
      corr_cnt_o     <= '0;
      uncorr_cnt_o   <= '0;
    end else begin
      if (state == ST_SHIFT)
        rx_code <= (rx_code >> LANES) | (SHIFT_W'(serial_o) << (SHIFT_W - LANES));
      rx_pending   <= last_beat;
      valid_out_o  <= rx_pending;
      err_corr_o   <= rx_pending && dec_bits[1];
      err_uncorr_o <= rx_pending && dec_bits[0];
      if (rx_pending) begin
        parallel_out_o <= dec_bits[DEC_W-1:2];
        if (dec_bits[1] && corr_cnt_o != '1)
          corr_cnt_o <= corr_cnt_o + 1'b1;
        if (dec_bits[0] && uncorr_cnt_o != '1)
          uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: doc/serdes_ecc_mlane.md
SERDES_ECC_MLANE -- requirements
Module: serdes_ecc_mlane

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per word (>=4).
REQ-002 Parameter FIFO_DEPTH, default 16, input FIFO entries (power of 2, >=2).
REQ-003 Parameter LANES, default 1, serial bits moved per cycle (1..CODE_WIDTH).
REQ-004 Parameter CNT_WIDTH, default 16, error counter width (>=2).
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 parallel_in_i  in  DATA_WIDTH  write data.
REQ-008 valid_in_i  in  1  write request.
REQ-009 ready_out_o  out  1  FIFO can accept a write.
REQ-010 inject_en_i  in  1  apply inject_mask_i to the next frame loaded.
REQ-011 inject_mask_i  in  CODE_WIDTH  XOR mask applied to the codeword at load.
REQ-012 serial_o  out  LANES  current TX beat (loopback observability).
REQ-013 busy_o  out  1  frame in flight.
REQ-014 parallel_out_o  out  DATA_WIDTH  decoded (corrected) data.
REQ-015 valid_out_o  out  1  one-cycle pulse per decoded word.
REQ-016 err_corr_o / err_uncorr_o  out  1 each  qualify valid_out_o: single-bit corrected / double-bit detected.
REQ-017 corr_cnt_o / uncorr_cnt_o  out  CNT_WIDTH each  saturating error counts.
REQ-018 fifo_full_o / fifo_empty_o  out  1 each  FIFO flags.

Function
REQ-019 P = smallest integer with 2^P >= DATA_WIDTH+P+1; CODE_WIDTH = DATA_WIDTH+P+1 (Hamming SECDED with overall parity at the MSB); BEATS = ceil(CODE_WIDTH/LANES), with the pad bits sent as zero.
REQ-020 ready_out_o = !fifo_full_o; a word is pushed on every edge where valid_in_i && ready_out_o; writes while full are dropped.
REQ-021 TX FSM has states IDLE and SHIFT.
REQ-022 IDLE -> SHIFT when the FIFO is non-empty: pop, load encode(word) ^ (inject_en_i ? inject_mask_i : 0), beat counter = 0.
REQ-023 In SHIFT, serial_o = codeword bits [beat*LANES +: LANES] (LSB first), and the beat counter increments each cycle.
REQ-024 On the last beat, if the FIFO is non-empty, pop and load the next word in the same edge (zero-bubble back-to-back); otherwise go to IDLE.
REQ-025 The RX deserializer captures each beat; after the last beat is captured, decode is registered, giving valid_out_o one cycle later.
REQ-026 Latency: a push into an empty FIFO with the FSM idle at edge 0 gives valid_out_o high after edge BEATS+2 (15 for the defaults).
REQ-027 Throughput: one word per BEATS cycles.
REQ-028 Decode with syndrome==0 and parity ok: no error.
REQ-029 Decode with parity bad (any syndrome): single-bit error, corrected, err_corr_o=1.
REQ-030 Decode with syndrome!=0 and parity ok: uncorrectable, err_uncorr_o=1, parallel_out_o = raw data bits.
REQ-031 Counters increment on each qualifying valid_out_o and hold at all-ones.
REQ-032 Simultaneous push and pop while full: the pop frees the entry, but ready_out_o is still the registered full flag, so the push is not accepted that cycle.
REQ-033 busy_o = (state==SHIFT) || RX decode pending.
REQ-034 A simultaneous push and pop on a FIFO with exactly one entry leaves that count unchanged.

Reset
REQ-035 Asynchronous assertion sets FSM=IDLE and clears FIFO pointers, shift and RX registers, and counters.
REQ-036 After reset: parallel_out_o=0, valid_out_o=0, err flags=0, serial_o=0, busy_o=0, fifo_empty_o=1, fifo_full_o=0, ready_out_o=1.
REQ-037 Reset mid-frame discards the frame; no valid_out_o pulse is produced for it.

Structure
REQ-038 serdes_ecc_pkg holds the calc_parity_bits/calc_code_width functions plus the secded_encode and secded_decode functions; the decode result is a struct of data, corr and uncorr.
REQ-039 The FIFO is one sub-module, sync_fifo (DATA_WIDTH, FIFO_DEPTH); the FSM, shifter, RX and counters live in serdes_ecc_mlane.

Verification
REQ-040 Defaults, push 0xA5 with no inject -> 0xA5 out 15 cycles later, err flags 0, counters 0.
REQ-041 inject_mask=0x0004 with data 0x3C -> out 0x3C, err_corr_o=1, corr_cnt_o=1; a mask of 0x1000 (overall parity bit) also counts as corrected.
REQ-042 inject_mask=0x0003 -> err_uncorr_o=1, uncorr_cnt_o=1, corr_cnt_o unchanged.
REQ-043 LANES=4, push 20 words back-to-back -> BEATS=4, valid_out_o every 4 cycles, ready_out_o low while 16 entries are held, all 20 words arrive in order.
REQ-044 CNT_WIDTH=2, 5 single-bit injections -> corr_cnt_o sticks at 3.
REQ-045 Assert rst_n_i during beat 6 -> outputs take reset values immediately; no valid_out_o for that word; the next push decodes correctly.
